// File: rtl/full_adder_model.sv
// Full adder with a registered copy of its result and a bit-serial accumulator.
// Operands are fed LSB first and assembled into result_q.
module full_adder_model #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             serial_start,
  input  logic             serial_en,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             carry_q,
  output logic [WIDTH-1:0] result_q,
  output logic             result_cout,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;
  logic             cin_eff;

  // While a serial word is running, the stored carry replaces the external carry-in
  always_comb begin
    cin_eff = serial_en ? carry_q : cin;
    sum     = a ^ b ^ cin_eff;
    cout    = (a & b) | (a & cin_eff) | (b & cin_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= 1'b0;
      cout_q      <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      result_cout <= 1'b0;
      done        <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      done   <= 1'b0;
      if (serial_start) begin
        carry_q  <= cin;
        bit_cnt  <= '0;
        result_q <= '0;
      end else if (serial_en) begin
        carry_q  <= cout;
        result_q <= {sum, result_q[WIDTH-1:1]};
        // The counter wraps so a following serial_en starts a new word on its own
        if (bit_cnt == LAST_BIT) begin
          done        <= 1'b1;
          result_cout <= cout;
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_full_adder_model.sv
// Directed bench for full_adder_model: truth table, serial adds, pauses and
// mid-word reset, with expected serial results held in a scoreboard queue.
module tb_full_adder_model;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             a, b, cin;
  logic             serial_start, serial_en;
  logic             sum, cout, sum_q, cout_q, carry_q;
  logic [WIDTH-1:0] result_q;
  logic             result_cout, done;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  full_adder_model #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .serial_start(serial_start), .serial_en(serial_en),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q),
    .carry_q(carry_q), .result_q(result_q), .result_cout(result_cout),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sa, input logic sb, input logic sc,
                               input logic st, input logic en);
    a = sa; b = sb; cin = sc; serial_start = st; serial_en = en;
  endtask

  // Serial add of two words; pause_at >= 0 idles serial_en for 3 cycles before that bit
  task automatic serialAdd(input string tag, input logic [WIDTH-1:0] wa,
                           input logic [WIDTH-1:0] wb, input logic ci,
                           input int pause_at);
    logic [WIDTH:0] total;
    exp_t e;
    exp_t got;
    total = {1'b0, wa} + {1'b0, wb} + {{WIDTH{1'b0}}, ci};
    e.res = total[WIDTH-1:0];
    e.co  = total[WIDTH];
    sb_q.push_back(e);
    applyStimulus(1'b0, 1'b0, ci, 1'b1, 1'b0);
    tick();
    checkOutput({tag, "_carry_start"}, 32'(carry_q), 32'(ci));
    checkOutput({tag, "_result_clear"}, 32'(result_q), 32'd0);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == pause_at) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
          tick();
          checkOutput({tag, "_pause_done"}, 32'(done), 32'd0);
        end
      end
      applyStimulus(wa[i], wb[i], 1'b0, 1'b0, 1'b1);
      tick();
      if (i < WIDTH - 1)
        checkOutput({tag, "_early_done"}, 32'(done), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      checkOutput({tag, "_result"}, 32'(result_q), 32'(got.res));
      checkOutput({tag, "_result_cout"}, 32'(result_cout), 32'(got.co));
      tick();
      checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      checkOutput({tag, "_result_hold"}, 32'(result_q), 32'(got.res));
      checkOutput({tag, "_cout_hold"}, 32'(result_cout), 32'(got.co));
    end
  endtask

  initial begin
    logic [1:0] tt_exp [8];
    logic [7:0] wa;
    logic [7:0] wb;
    tt_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_sum_q", 32'(sum_q), 32'd0);
    checkOutput("reset_carry_q", 32'(carry_q), 32'd0);
    checkOutput("reset_result_q", 32'(result_q), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Truth table: (a,b,cin) 000..111, expected {sum,cout}
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[2], i[1], i[0], 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("tt%0d_sum", i), 32'(sum), 32'(tt_exp[i][1]));
      checkOutput($sformatf("tt%0d_cout", i), 32'(cout), 32'(tt_exp[i][0]));
      tick();
      checkOutput($sformatf("tt%0d_sum_q", i), 32'(sum_q), 32'(tt_exp[i][1]));
      checkOutput($sformatf("tt%0d_cout_q", i), 32'(cout_q), 32'(tt_exp[i][0]));
    end

    serialAdd("add35_0f", 8'h35, 8'h0F, 1'b0, -1);
    checkOutput("add35_0f_const", 32'(result_q), 32'h44);
    serialAdd("ovf_ff_01", 8'hFF, 8'h01, 1'b0, -1);
    checkOutput("ovf_const_res", 32'(result_q), 32'h00);
    checkOutput("ovf_const_cout", 32'(result_cout), 32'd1);
    serialAdd("cin_00_00", 8'h00, 8'h00, 1'b1, -1);
    checkOutput("cin_const_res", 32'(result_q), 32'h01);
    checkOutput("cin_const_cout", 32'(result_cout), 32'd0);
    serialAdd("pause", 8'h35, 8'h0F, 1'b0, 4);
    checkOutput("pause_const_res", 32'(result_q), 32'h44);

    // Mid-word reset: four bits of a word, then reset abandons it
    wa = 8'hFF;
    wb = 8'hFF;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(wa[i], wb[i], 1'b0, 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("rst_comb_cout", 32'(cout), 32'(carry_q | 1'b1));
    tick();
    checkOutput("midrst_sum_q", 32'(sum_q), 32'd0);
    checkOutput("midrst_cout_q", 32'(cout_q), 32'd0);
    checkOutput("midrst_carry_q", 32'(carry_q), 32'd0);
    checkOutput("midrst_result_q", 32'(result_q), 32'd0);
    checkOutput("midrst_result_cout", 32'(result_cout), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    #1;
    checkOutput("rst_comb_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("post_rst_no_done", 32'(done), 32'd0);
    end
    serialAdd("after_rst", 8'h35, 8'h0F, 1'b0, -1);
    checkOutput("after_rst_const", 32'(result_q), 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
